// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencing controller:
//   - mem_state_t : states of the SRAM wait FSM (IDLE, ACCESS, DONE)
//   - default values for register-index width, SRAM latency, counter widths
//   - ctrl_word_t / NOP_CTRL : control word that bubble_EXE consumers load
//     into the ID/EXE register when a bubble is inserted
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_W_DEF       = 5;
    localparam int MEM_LATENCY_DEF = 6;
    localparam int CNT_W_DEF       = 3;
    localparam int PERF_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Control fields carried in ID/EXE; a bubble is all-zero, so the
    // injected instruction neither writes registers nor touches SRAM.
    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       branch;
        logic [3:0] exe_cmd;
    } ctrl_word_t;

    localparam ctrl_word_t NOP_CTRL = '0;

endpackage

// File: rtl/mem_wait_fsm.sv
// ---------------------------------------------------------------------------
// mem_wait_fsm
// Freezes the whole pipeline while a multi-cycle SRAM access sits in MEM.
// A memory instruction stays frozen for MEM_LATENCY+1 cycles (the IDLE cycle
// that detects it plus MEM_LATENCY cycles in ACCESS) and leaves on DONE.
// Ports:
//   clk, rst    : core clock, synchronous active-high reset
//   mem_acc     : MEM instruction reads or writes SRAM
//   freeze_all  : hold every pipeline register
//   mem_done    : one-cycle pulse on the cycle the access completes
// ---------------------------------------------------------------------------
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_acc,
    output logic freeze_all,
    output logic mem_done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;

    // State register and latency counter. DONE never waits, so a memory op
    // arriving right behind the previous one is picked up in IDLE on the
    // following cycle without any lost cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_acc) begin
                        state <= ACCESS;
                        cnt   <= CNT_LOAD;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // The freeze must already be visible in the IDLE cycle that first sees
    // the access, so it is decoded from the state rather than registered.
    always_comb begin
        freeze_all = 1'b0;
        mem_done   = 1'b0;
        if (!rst) begin
            freeze_all = (state == ACCESS) || ((state == IDLE) && mem_acc);
            mem_done   = (state == DONE);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall / freeze / bubble / flush controller for the 5-stage core.
// Build option: define PIPE_FORWARDING_EN when the forwarding unit is
// present; then only load-use hazards stall. Without it every RAW against
// the EXE or MEM instruction stalls (up to two bubbles).
// Ports:
//   clk, rst                       : core clock, synchronous active-high reset
//   src1_ID, src2_ID, two_src_ID   : source operands of the ID instruction
//   dest_EXE, WB_EN_EXE, MEM_R_EN_EXE : EXE instruction destination/controls
//   dest_MEM, WB_EN_MEM            : MEM instruction destination/write enable
//   MEM_R_EN_MEM, MEM_W_EN_MEM     : MEM instruction SRAM access
//   branch_taken                   : branch resolved taken in EXE
//   freeze_all    : hold every pipeline register (SRAM busy)
//   freeze_front  : hold PC and IF/ID
//   bubble_EXE    : load NOP_CTRL into ID/EXE
//   flush         : squash IF/ID and ID/EXE
//   mem_done      : SRAM access complete pulse
//   stall_cycles  : saturating count of freeze_front cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PERF_W      = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  src1_ID,
    input  logic [REG_W-1:0]  src2_ID,
    input  logic              two_src_ID,
    input  logic [REG_W-1:0]  dest_EXE,
    input  logic              WB_EN_EXE,
    input  logic              MEM_R_EN_EXE,
    input  logic [REG_W-1:0]  dest_MEM,
    input  logic              WB_EN_MEM,
    input  logic              MEM_R_EN_MEM,
    input  logic              MEM_W_EN_MEM,
    input  logic              branch_taken,
    output logic              freeze_all,
    output logic              freeze_front,
    output logic              bubble_EXE,
    output logic              flush,
    output logic              mem_done,
    output logic [PERF_W-1:0] stall_cycles
);

    logic              mem_acc;
    logic              match_exe;
    logic              haz;
    logic [PERF_W-1:0] stall_cnt;

    assign mem_acc   = MEM_R_EN_MEM | MEM_W_EN_MEM;
    assign match_exe = (src1_ID == dest_EXE) | (two_src_ID & (src2_ID == dest_EXE));

`ifdef PIPE_FORWARDING_EN
    // Forwarding covers everything except a load whose data is not yet back.
    logic unused_mem_fields;
    assign unused_mem_fields = ^{dest_MEM, WB_EN_MEM};
    assign haz = WB_EN_EXE & MEM_R_EN_EXE & match_exe;
`else
    // No forwarding: wait until neither in-flight writer matches a source.
    logic match_mem;
    logic unused_exe_load;
    assign unused_exe_load = MEM_R_EN_EXE;
    assign match_mem = (src1_ID == dest_MEM) | (two_src_ID & (src2_ID == dest_MEM));
    assign haz       = (WB_EN_EXE & match_exe) | (WB_EN_MEM & match_mem);
`endif

    mem_wait_fsm #(
        .MEM_LATENCY (MEM_LATENCY),
        .CNT_W       (CNT_W)
    ) u_mem_wait (
        .clk        (clk),
        .rst        (rst),
        .mem_acc    (mem_acc),
        .freeze_all (freeze_all),
        .mem_done   (mem_done)
    );

    // Priority: a frozen pipeline holds its inputs, so branch and hazard are
    // simply re-evaluated once the freeze lifts. A taken branch squashes the
    // ID instruction, which makes any hazard it carries irrelevant.
    always_comb begin
        freeze_front = 1'b0;
        bubble_EXE   = 1'b0;
        flush        = 1'b0;
        if (!rst) begin
            if (freeze_all) begin
                freeze_front = 1'b1;
            end else if (branch_taken) begin
                flush = 1'b1;
            end else if (haz) begin
                freeze_front = 1'b1;
                bubble_EXE   = 1'b1;
            end
        end
    end

    // Stall counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (freeze_front && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

    assign stall_cycles = rst ? '0 : stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by randomized traffic against a cycle-level
// reference model. The SRAM wait is modelled as the age of the access in
// cycles; the stall counter uses a small PERF_W so saturation is reached.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_W  = 5;
    localparam int LAT    = 6;
    localparam int CNT_W  = 3;
    localparam int PERF_W = 6;
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_W-1:0]  src1_ID, src2_ID, dest_EXE, dest_MEM;
    logic              two_src_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM;
    logic              MEM_R_EN_MEM, MEM_W_EN_MEM, branch_taken;
    logic              freeze_all, freeze_front, bubble_EXE, flush, mem_done;
    logic [PERF_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int age      = -1;
    int stall_model = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W       (REG_W),
        .MEM_LATENCY (LAT),
        .CNT_W       (CNT_W),
        .PERF_W      (PERF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src1_ID      (src1_ID),
        .src2_ID      (src2_ID),
        .two_src_ID   (two_src_ID),
        .dest_EXE     (dest_EXE),
        .WB_EN_EXE    (WB_EN_EXE),
        .MEM_R_EN_EXE (MEM_R_EN_EXE),
        .dest_MEM     (dest_MEM),
        .WB_EN_MEM    (WB_EN_MEM),
        .MEM_R_EN_MEM (MEM_R_EN_MEM),
        .MEM_W_EN_MEM (MEM_W_EN_MEM),
        .branch_taken (branch_taken),
        .freeze_all   (freeze_all),
        .freeze_front (freeze_front),
        .bubble_EXE   (bubble_EXE),
        .flush        (flush),
        .mem_done     (mem_done),
        .stall_cycles (stall_cycles)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, observed, expected);
        end
    endtask

    task automatic clearInputs();
        rst = 1'b0;
        src1_ID = 1; src2_ID = 2; two_src_ID = 1'b0;
        dest_EXE = 10; WB_EN_EXE = 1'b0; MEM_R_EN_EXE = 1'b0;
        dest_MEM = 11; WB_EN_MEM = 1'b0;
        MEM_R_EN_MEM = 1'b0; MEM_W_EN_MEM = 1'b0; branch_taken = 1'b0;
    endtask

    // One clock cycle: predict outputs from the current inputs, compare on
    // the falling edge, then advance the model across the rising edge.
    task automatic applyStimulus();
        bit mem_acc, m_exe, m_mem, haz;
        bit e_fa, e_done, e_ff, e_bub, e_flush;
        int e_stall;
        mem_acc = MEM_R_EN_MEM || MEM_W_EN_MEM;
        m_exe = (src1_ID == dest_EXE) || (two_src_ID && src2_ID == dest_EXE);
        m_mem = (src1_ID == dest_MEM) || (two_src_ID && src2_ID == dest_MEM);
`ifdef PIPE_FORWARDING_EN
        haz = WB_EN_EXE && MEM_R_EN_EXE && m_exe;
`else
        haz = (WB_EN_EXE && m_exe) || (WB_EN_MEM && m_mem);
`endif
        if (rst) begin
            e_fa = 0; e_done = 0; e_ff = 0; e_bub = 0; e_flush = 0; e_stall = 0;
        end else begin
            e_fa    = (age < 0) ? mem_acc : (age <= LAT);
            e_done  = (age == LAT + 1);
            e_ff    = e_fa || (!branch_taken && haz);
            e_bub   = !e_fa && !branch_taken && haz;
            e_flush = !e_fa && branch_taken;
            e_stall = stall_model;
        end
        @(negedge clk);
        checkOutput("freeze_all",   int'(freeze_all),   int'(e_fa));
        checkOutput("mem_done",     int'(mem_done),     int'(e_done));
        checkOutput("freeze_front", int'(freeze_front), int'(e_ff));
        checkOutput("bubble_EXE",   int'(bubble_EXE),   int'(e_bub));
        checkOutput("flush",        int'(flush),        int'(e_flush));
        checkOutput("stall_cycles", int'(stall_cycles), e_stall);
        @(posedge clk);
        if (rst) begin
            age = -1;
            stall_model = 0;
        end else begin
            if (e_ff && stall_model < PERF_MAX) stall_model++;
            if (age < 0)         age = mem_acc ? 1 : -1;
            else if (age <= LAT) age++;
            else                 age = -1;
        end
        cycle++;
        #1;
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        clearInputs();

        // Load to R3 in EXE, ID reads R3
        WB_EN_EXE = 1; MEM_R_EN_EXE = 1; dest_EXE = 3; src1_ID = 3;
        applyStimulus();
        clearInputs();
        applyStimulus();

        // SRAM read held through freeze, done and the next access
        MEM_R_EN_MEM = 1;
        for (int i = 0; i < 10; i++) applyStimulus();
        clearInputs();
        for (int i = 0; i < 8; i++) applyStimulus();

        // Branch together with a load-use hazard
        WB_EN_EXE = 1; MEM_R_EN_EXE = 1; dest_EXE = 4; src2_ID = 4; two_src_ID = 1;
        branch_taken = 1;
        applyStimulus();
        clearInputs();

        // Branch arriving during an access
        MEM_W_EN_MEM = 1;
        applyStimulus();
        branch_taken = 1;
        for (int i = 0; i < 7; i++) applyStimulus();
        clearInputs();
        applyStimulus();

        // Reset in the middle of an access
        MEM_R_EN_MEM = 1;
        for (int i = 0; i < 4; i++) applyStimulus();
        rst = 1;
        applyStimulus();
        clearInputs();
        applyStimulus();

        // ADD to R5 in EXE, then in MEM, ID reads src2=R5
        WB_EN_EXE = 1; dest_EXE = 5; src2_ID = 5; two_src_ID = 1;
        applyStimulus();
        WB_EN_EXE = 0; dest_EXE = 0; WB_EN_MEM = 1; dest_MEM = 5;
        applyStimulus();
        clearInputs();
        applyStimulus();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            src1_ID      = REG_W'($urandom_range(0, 3));
            src2_ID      = REG_W'($urandom_range(0, 3));
            two_src_ID   = 1'($urandom);
            dest_EXE     = REG_W'($urandom_range(0, 3));
            dest_MEM     = REG_W'($urandom_range(0, 3));
            WB_EN_EXE    = 1'($urandom);
            MEM_R_EN_EXE = 1'($urandom);
            WB_EN_MEM    = 1'($urandom);
            MEM_R_EN_MEM = ($urandom_range(0, 9) == 0);
            MEM_W_EN_MEM = ($urandom_range(0, 15) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core (IF/ID/EXE/MEM/WB).
- Sits beside the forwarding unit and produces every stall, freeze, bubble and flush control for the pipeline registers.
- Detects load-use (or full RAW) hazards at ID, flushes on taken branches, and runs a counter-based FSM that freezes the pipeline while a multi-cycle SRAM access completes in MEM.

Parameters:
- REG_W, 5, register-index width (matches dest_* fields in the datapath).
- MEM_LATENCY, 6, SRAM access length in cycles; legal range 1..(2^CNT_W).
- CNT_W, 3, latency counter width.
- PERF_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- src1_ID  in  REG_W  first source register of the instruction in ID.
- src2_ID  in  REG_W  second source register of the instruction in ID.
- two_src_ID  in  1  instruction in ID reads src2 (register operand / store).
- dest_EXE  in  REG_W  destination register of the EXE instruction.
- WB_EN_EXE  in  1  EXE instruction writes the register file.
- MEM_R_EN_EXE  in  1  EXE instruction is a load.
- dest_MEM  in  REG_W  destination register of the MEM instruction.
- WB_EN_MEM  in  1  MEM instruction writes the register file.
- MEM_R_EN_MEM  in  1  MEM instruction reads SRAM.
- MEM_W_EN_MEM  in  1  MEM instruction writes SRAM.
- branch_taken  in  1  branch resolved taken in EXE.
- freeze_all  out  1  hold every pipeline register (SRAM busy).
- freeze_front  out  1  hold PC and IF/ID register.
- bubble_EXE  out  1  load NOP into the ID/EXE register.
- flush  out  1  squash IF/ID and ID/EXE contents.
- mem_done  out  1  one-cycle pulse: SRAM access complete.
- stall_cycles  out  PERF_W  saturating count of cycles with freeze_front=1.

Behaviour:
- All outputs 0 while rst=1. Reset returns FSM to IDLE, cnt=0, stall_cycles=0; an access in flight is abandoned.
- mem_acc = MEM_R_EN_MEM | MEM_W_EN_MEM.
- FSM states:
  - IDLE:
    - mem_acc=1 -> ACCESS, cnt <= MEM_LATENCY-1, freeze_all=1 this cycle (combinational).
    - Otherwise stay in IDLE.
  - ACCESS: freeze_all=1; cnt decrements each cycle; cnt==0 -> DONE.
  - DONE: freeze_all=0; mem_done=1; pipeline advances; unconditionally -> IDLE.
- Timing: a memory instruction is frozen in MEM for exactly MEM_LATENCY+1 cycles and leaves on the DONE cycle.
- Back-to-back memory ops: the second op is seen in IDLE on the cycle after DONE, with no lost or extra cycles beyond MEM_LATENCY+1 each.
- Hazard (forwarding build): haz = WB_EN_EXE & MEM_R_EN_EXE & (src1_ID==dest_EXE | (two_src_ID & src2_ID==dest_EXE)).
- Priority, highest first:
  1. freeze_all: forces freeze_front=1, bubble_EXE=0, flush=0. Branch and hazard are re-evaluated after the freeze ends, because the inputs are held.
  2. branch_taken: flush=1, freeze_front=0, bubble_EXE=0. The hazard is ignored because the ID instruction is squashed.
  3. haz: freeze_front=1, bubble_EXE=1.
- Load-use stall lasts exactly 1 cycle; after the bubble the load is in MEM and forwarding covers it.
- stall_cycles increments when freeze_front=1. It saturates at all-ones and does not wrap.
- Register index 0 is not special; comparisons are plain equality.

Optional Feature:
- Macro: PIPE_FORWARDING_EN.
- Defined: hazard rule as above (load-use only).
- Undefined (no forwarding): haz = RAW against EXE or MEM.
  - Source match = src1_ID==d | (two_src_ID & src2_ID==d).
  - haz = (WB_EN_EXE & source match on dest_EXE) | (WB_EN_MEM & source match on dest_MEM).
  - Stall repeats each cycle until neither matches, giving up to 2 bubbles.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the FSM state enum (IDLE, ACCESS, DONE);
  - REG_W / MEM_LATENCY defaults;
  - the NOP control-word constant used by bubble_EXE consumers.
- One natural sub-module: mem_wait_fsm (state register, latency counter, freeze_all, mem_done).
- Hazard and priority logic stay in the top level.

Test Plan:
- Load to R3 in EXE, ID reads src1=R3 -> freeze_front=1 and bubble_EXE=1 for exactly 1 cycle; stall_cycles=1.
- MEM_R_EN_MEM=1 with MEM_LATENCY=6 -> freeze_all high for 7 cycles, then mem_done pulses once with freeze_all=0; next op frozen again from the following cycle.
- branch_taken=1 together with a load-use hazard -> flush=1, bubble_EXE=0, freeze_front=0.
- branch_taken=1 during ACCESS -> flush=0 until the DONE cycle; flush asserts on the first unfrozen cycle.
- rst asserted at cnt=3 in ACCESS -> next cycle state IDLE, all outputs 0, stall_cycles=0.
- Without PIPE_FORWARDING_EN: ADD writing R5 in EXE, ID reads src2=R5 with two_src_ID=1 -> 2 consecutive bubble cycles.
- With PIPE_FORWARDING_EN, same ADD case -> no stall.
